// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store Wishbone master: RV32 width codes,
// FSM state encoding and the access-size byte mask.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Lane mask of an access at lane 0; size is funct3[1:0].
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/wishbone.sv
// Classic Wishbone bus bundle with master and slave views.
interface wishbone #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   ADR;
  logic [XLEN/8-1:0] SEL;
  logic              WE;
  logic              STB;
  logic [XLEN-1:0]   DAT_W;
  logic [XLEN-1:0]   DAT_R;
  logic              ACK;

  modport MASTER (output ADR, SEL, WE, STB, DAT_W, input DAT_R, ACK);
  modport SLAVE  (input ADR, SEL, WE, STB, DAT_W, output DAT_R, ACK);
endinterface

// File: rtl/wb_lane_align.sv
// Combinational lane steering: access legality, byte selects, store data
// placement and load data extraction with sign/zero extension.
module wb_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            we,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            fault,
  output logic [3:0]      sel,
  output logic [XLEN-1:0] dat_w,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted_s;

  assign sel       = size_mask(funct3[1:0]) << addr_lo;
  assign dat_w     = wdata << {addr_lo, 3'b000};
  assign shifted_s = bus_rdata >> {addr_lo, 3'b000};

  // Illegal width codes, unsigned stores and misaligned halfword/word accesses.
  always_comb begin
    fault = 1'b0;
    case (funct3)
      F3_B, F3_BU: fault = we && funct3[2];
      F3_H, F3_HU: fault = (we && funct3[2]) || addr_lo[0];
      F3_W:        fault = (addr_lo != 2'b00);
      default:     fault = 1'b1;
    endcase
  end

  // Truncate the lane-shifted read data to the access size and extend it.
  always_comb begin
    load_data = {XLEN{1'b0}};
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
      F3_H:    load_data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
      F3_W:    load_data = shifted_s;
      default: load_data = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// Load/store unit front end: accepts one request, runs one classic Wishbone
// cycle (or short-circuits a faulting access) and returns a one-cycle response.
module lsu_wb_master
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  wishbone.MASTER         wb
);

  lsu_state_e      state_r, state_s;
  logic [2:0]      funct3_r, funct3_s;
  logic [1:0]      addr_lo_r, addr_lo_s;
  logic            we_r, we_s;
  logic [XLEN-1:0] adr_r, adr_s;
  logic [3:0]      sel_r, sel_s;
  logic            we_bus_r, we_bus_s;
  logic            stb_r, stb_s;
  logic [XLEN-1:0] dat_w_r, dat_w_s;
  logic            resp_valid_r, resp_valid_s;
  logic            resp_fault_r, resp_fault_s;
  logic [XLEN-1:0] resp_rdata_r, resp_rdata_s;

  logic [2:0]      align_funct3_s;
  logic [1:0]      align_addr_lo_s;
  logic            align_we_s;
  logic            align_fault_s;
  logic [3:0]      align_sel_s;
  logic [XLEN-1:0] align_dat_w_s;
  logic [XLEN-1:0] align_load_s;

  // In IDLE the aligner judges the incoming request; afterwards it extracts
  // load data for the latched request.
  assign align_funct3_s  = (state_r == IDLE) ? req_funct3    : funct3_r;
  assign align_addr_lo_s = (state_r == IDLE) ? req_addr[1:0] : addr_lo_r;
  assign align_we_s      = (state_r == IDLE) ? req_we        : we_r;

  wb_lane_align #(.XLEN(XLEN)) u_align (
    .funct3    (align_funct3_s),
    .we        (align_we_s),
    .addr_lo   (align_addr_lo_s),
    .wdata     (req_wdata),
    .bus_rdata (wb.DAT_R),
    .fault     (align_fault_s),
    .sel       (align_sel_s),
    .dat_w     (align_dat_w_s),
    .load_data (align_load_s)
  );

  assign req_ready  = (state_r == IDLE) && !reset;
  assign resp_valid = resp_valid_r;
  assign resp_fault = resp_fault_r;
  assign resp_rdata = resp_rdata_r;
  assign wb.ADR     = adr_r;
  assign wb.SEL     = sel_r;
  assign wb.WE      = we_bus_r;
  assign wb.STB     = stb_r;
  assign wb.DAT_W   = dat_w_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus next values of the request latch, bus and response registers.
  always_comb begin
    state_s      = state_r;
    funct3_s     = funct3_r;
    addr_lo_s    = addr_lo_r;
    we_s         = we_r;
    adr_s        = adr_r;
    sel_s        = sel_r;
    we_bus_s     = we_bus_r;
    stb_s        = stb_r;
    dat_w_s      = dat_w_r;
    resp_valid_s = 1'b0;
    resp_fault_s = resp_fault_r;
    resp_rdata_s = resp_rdata_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          funct3_s  = req_funct3;
          addr_lo_s = req_addr[1:0];
          we_s      = req_we;
          if (align_fault_s) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_fault_s = 1'b1;
            resp_rdata_s = {XLEN{1'b0}};
          end else begin
            state_s  = BUS;
            adr_s    = {req_addr[XLEN-1:2], 2'b00};
            sel_s    = align_sel_s;
            we_bus_s = req_we;
            stb_s    = 1'b1;
            dat_w_s  = align_dat_w_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        if (wb.ACK && stb_r) begin
          state_s      = RESP;
          stb_s        = 1'b0;
          we_bus_s     = 1'b0;
          sel_s        = 4'b0000;
          resp_valid_s = 1'b1;
          resp_fault_s = 1'b0;
          resp_rdata_s = we_r ? {XLEN{1'b0}} : align_load_s;
        end else begin
          state_s = BUS;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        stb_s   = 1'b0;
      end
    endcase
  end

  // Request latch, registered bus outputs and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_r     <= 3'b000;
      addr_lo_r    <= 2'b00;
      we_r         <= 1'b0;
      adr_r        <= {XLEN{1'b0}};
      sel_r        <= 4'b0000;
      we_bus_r     <= 1'b0;
      stb_r        <= 1'b0;
      dat_w_r      <= {XLEN{1'b0}};
      resp_valid_r <= 1'b0;
      resp_fault_r <= 1'b0;
      resp_rdata_r <= {XLEN{1'b0}};
    end else begin
      funct3_r     <= funct3_s;
      addr_lo_r    <= addr_lo_s;
      we_r         <= we_s;
      adr_r        <= adr_s;
      sel_r        <= sel_s;
      we_bus_r     <= we_bus_s;
      stb_r        <= stb_s;
      dat_w_r      <= dat_w_s;
      resp_valid_r <= resp_valid_s;
      resp_fault_r <= resp_fault_s;
      resp_rdata_r <= resp_rdata_s;
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Self-checking bench for lsu_wb_master: a transaction-level model predicts
// every cycle's bus and response outputs; directed loads/stores pin the model.
module tb_lsu_wb_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  wishbone #(.XLEN(32)) wb_bus ();

  lsu_wb_master #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .wb         (wb_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Wishbone slave: acks after slave_waits wait states; late_ack forces ACK next cycle.
  logic [31:0] slave_rdata = 32'h0;
  int          slave_waits = 0;
  int          stb_cnt = 0;
  bit          late_ack = 1'b0;
  assign wb_bus.DAT_R = slave_rdata;
  initial wb_bus.ACK = 1'b0;
  always @(posedge clk) begin
    #1;
    if (wb_bus.STB === 1'b1) begin
      wb_bus.ACK = (stb_cnt == slave_waits) || late_ack;
      stb_cnt++;
    end else begin
      wb_bus.ACK = late_ack;
      stb_cnt = 0;
    end
  end

  // Reference rules
  function automatic bit model_fault(input bit we, input int f3, input int unsigned addr);
    int sz;
    if (!(f3 inside {0, 1, 2, 4, 5})) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    sz = 1 << (f3 % 4);
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input int off, input logic [31:0] dat);
    longint unsigned v;
    longint unsigned lim;
    int nb;
    nb  = 1 << (f3 % 4);
    v   = longint'(dat) >> (8 * off);
    lim = longint'(1) << (8 * nb);
    v   = v % lim;
    if (f3 < 4 && v >= (lim >> 1)) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  // Model state for the transaction in flight
  bit          m_active = 1'b0;
  bit          m_we, m_fault;
  int          m_off, m_a, m_w, m_r;
  int          m_free_at = 0;
  int          m_acc_cnt = 0;
  logic [31:0] m_addr, m_wdata, m_exp_rdata;
  logic [3:0]  m_sel;

  // DUT observations used by the literal checks
  int          dut_acc_c = 0, dut_rv_c = 0, dut_stb_n = 0, rv_total = 0;
  logic [31:0] got_adr, got_datw, got_rdata;
  logic [3:0]  got_sel;
  logic        got_we, got_fault;

  bit exp_ready, exp_stb, exp_rv;

  // Compare process: every cycle against the model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_ready = !reset && (cyc >= m_free_at);
      exp_stb   = m_active && !m_fault && (cyc >= m_a) && (cyc <= m_a + m_w);
      exp_rv    = m_active && (cyc == m_r);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("stb", 32'(wb_bus.STB), 32'(exp_stb));
      chk("we", 32'(wb_bus.WE), 32'(exp_stb && m_we));
      chk("sel", 32'(wb_bus.SEL), exp_stb ? 32'(m_sel) : 32'h0);
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_stb) begin
        chk("adr", wb_bus.ADR, m_addr - (m_addr % 4));
        for (int i = 0; i < 4; i++)
          if (m_sel[i])
            chk("dat_w_lane", (wb_bus.DAT_W >> (8 * i)) & 32'hFF,
                (m_wdata >> (8 * (i - m_off))) & 32'hFF);
      end
      if (exp_rv) begin
        chk("resp_rdata", resp_rdata, m_exp_rdata);
        chk("resp_fault", 32'(resp_fault), 32'(m_fault));
      end

      if (wb_bus.STB === 1'b1) begin
        if (dut_stb_n == 0) begin
          got_adr  = wb_bus.ADR;
          got_sel  = wb_bus.SEL;
          got_we   = wb_bus.WE;
          got_datw = wb_bus.DAT_W;
        end
        dut_stb_n++;
      end
      if (resp_valid === 1'b1) begin
        got_rdata = resp_rdata;
        got_fault = resp_fault;
        dut_rv_c  = cyc;
        rv_total++;
      end
      if (req_valid && req_ready === 1'b1 && !reset) begin
        dut_acc_c = cyc;
        dut_stb_n = 0;
      end

      if (reset) begin
        m_active  = 1'b0;
        m_free_at = cyc + 1;
      end else if (m_active && cyc == m_r) begin
        m_active = 1'b0;
      end
      if (!reset && req_valid && exp_ready) begin
        m_active    = 1'b1;
        m_we        = req_we;
        m_addr      = req_addr;
        m_wdata     = req_wdata;
        m_off       = int'(req_addr % 4);
        m_fault     = model_fault(req_we, int'(req_funct3), req_addr);
        m_sel       = 4'((((1 << (1 << (req_funct3 % 4))) - 1) << m_off) % 16);
        m_exp_rdata = (m_fault || req_we) ? 32'h0
                      : model_load(int'(req_funct3), m_off, slave_rdata);
        m_a         = cyc + 1;
        m_w         = slave_waits;
        m_r         = m_fault ? m_a : m_a + m_w + 1;
        m_free_at   = m_r + 1;
        m_acc_cnt++;
      end
    end
  end

  task automatic wait_acc(input int n0);
    int k = 0;
    while (m_acc_cnt == n0 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    if (m_acc_cnt == n0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: request not accepted within 40 cycles");
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_active || cyc < m_free_at) && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (m_active || cyc < m_free_at) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: transaction not finished within 200 cycles");
    end
  endtask

  task automatic set_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    req_we      = we;
    req_funct3  = f3;
    req_addr    = addr;
    req_wdata   = wdata;
    slave_rdata = rdata;
    slave_waits = waits;
    req_valid   = 1'b1;
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    int n0;
    @(posedge clk); #2;
    n0 = m_acc_cnt;
    set_req(we, f3, addr, wdata, rdata, waits);
    wait_acc(n0);
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_idle();
  endtask

  int rv_before;
  int n0;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_adr", wb_bus.ADR, 32'h0);
    chk("rst_dat_w", wb_bus.DAT_W, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_fault", 32'(resp_fault), 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    // LB at 0x1003, zero wait
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8000_0000, 0);
    chk("lb_sel", 32'(got_sel), 32'h8);
    chk("lb_adr", got_adr, 32'h0000_1000);
    chk("lb_rdata", got_rdata, 32'hFFFF_FF80);
    chk("lb_latency", 32'(dut_rv_c - dut_acc_c), 32'd2);

    // LHU at 0x2002, three wait states
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3);
    chk("lhu_stb_cycles", 32'(dut_stb_n), 32'd4);
    chk("lhu_sel", 32'(got_sel), 32'hC);
    chk("lhu_rdata", got_rdata, 32'h0000_BEEF);
    chk("lhu_latency", 32'(dut_rv_c - dut_acc_c), 32'd5);

    // Misaligned SH and LW fault without a bus cycle
    issue(1'b1, 3'b001, 32'h0000_0101, 32'hABCD_5678, 32'h0, 0);
    chk("sh_fault", 32'(got_fault), 32'h1);
    chk("sh_rdata", got_rdata, 32'h0);
    chk("sh_latency", 32'(dut_rv_c - dut_acc_c), 32'd1);
    chk("sh_no_stb", 32'(dut_stb_n), 32'd0);
    issue(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1234_5678, 0);
    chk("lw_fault", 32'(got_fault), 32'h1);
    chk("lw_rdata", got_rdata, 32'h0);
    chk("lw_no_stb", 32'(dut_stb_n), 32'd0);

    // SB 0xA5 at 0x3001
    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'hFFFF_FFFF, 1);
    chk("sb_we", 32'(got_we), 32'h1);
    chk("sb_sel", 32'(got_sel), 32'h2);
    chk("sb_lane1", 32'(got_datw[15:8]), 32'hA5);
    chk("sb_fault", 32'(got_fault), 32'h0);
    chk("sb_rdata", got_rdata, 32'h0);

    // More width/alignment cases
    issue(1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
    chk("lh_rdata", got_rdata, 32'hFFFF_8001);
    issue(1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_FF00, 2);
    chk("lbu_rdata", got_rdata, 32'h0000_00FF);
    issue(1'b1, 3'b010, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sw_datw", got_datw, 32'hDEAD_BEEF);
    chk("sw_sel", 32'(got_sel), 32'hF);
    issue(1'b0, 3'b011, 32'h0000_0008, 32'h0, 32'h0, 0);
    chk("f3_011_fault", 32'(got_fault), 32'h1);
    issue(1'b1, 3'b100, 32'h0000_0008, 32'h0, 32'h0, 0);
    chk("sbu_fault", 32'(got_fault), 32'h1);

    // Back-to-back loads with req_valid held high
    @(posedge clk); #2;
    n0 = m_acc_cnt;
    set_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1122_3344, 0);
    wait_acc(n0);
    @(posedge clk); #2;
    req_funct3 = 3'b100;
    req_addr   = 32'h0000_0023;
    wait_acc(n0 + 1);
    chk("b2b_first_rdata", got_rdata, 32'h1122_3344);
    chk("b2b_gap", 32'(dut_acc_c - dut_rv_c), 32'd1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    wait_idle();
    chk("b2b_second_rdata", got_rdata, 32'h0000_0011);

    // Reset while waiting for ACK, then a late ACK
    @(posedge clk); #2;
    n0 = m_acc_cnt;
    set_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 100);
    wait_acc(n0);
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rv_before = rv_total;
    reset    = 1'b1;
    late_ack = 1'b1;
    @(posedge clk); #2;
    reset    = 1'b0;
    late_ack = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_stb", 32'(wb_bus.STB), 32'h0);
    chk("rst_mid_ready", 32'(req_ready), 32'h1);
    repeat (4) @(negedge clk);
    #1;
    chk("rst_mid_no_resp", 32'(rv_total), 32'(rv_before));

    // Normal operation after the aborted access
    issue(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1);
    chk("post_rst_rdata", got_rdata, 32'hCAFE_F00D);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
